// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
`include "constants.svh"

package regfile_pkg;

  localparam int WORD_W = `WORD_WIDTH;
  localparam int REG_N  = `REG_COUNT;

  // Address width for a register count that need not be a power of two.
  function automatic int aw_of(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int AW = aw_of(REG_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  typedef logic [AW-1:0]     addr_t;
  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/constants.svh
// Core-wide register file geometry shared by the datapath.
`ifndef REGFILE_CONSTANTS_SVH
`define REGFILE_CONSTANTS_SVH
`define WORD_WIDTH 32
`define REG_COUNT 32
`endif

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer: walks every register index once, then pulses done.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int COUNT = `REG_COUNT,
  parameter int AWP   = aw_of(`REG_COUNT)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_req_i,
  output logic           clr_busy_o,
  output logic           clr_done_o,
  output logic           sweep_en_o,
  output logic [AWP-1:0] sweep_addr_o
);

  clr_state_t     state_q, state_d;
  logic [AWP-1:0] ptr_q, ptr_d;

  // State and sweep pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic; clr_req only matters in IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        if (ptr_q == AWP'(COUNT - 1)) begin
          state_d = DONE;
          ptr_d   = '0;
        end else begin
          state_d = SWEEP;
          ptr_d   = ptr_q + AWP'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign clr_busy_o   = (state_q == SWEEP);
  assign clr_done_o   = (state_q == DONE);
  assign sweep_en_o   = (state_q == SWEEP);
  assign sweep_addr_o = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write priority, optional bypass/zero
// register, and a sequential bulk-clear engine.
`include "constants.svh"

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = `WORD_WIDTH,
  parameter int COUNT    = `REG_COUNT,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int BYPASS   = 0,
  parameter int ZERO_REG = 0,
  localparam int AWP     = aw_of(COUNT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NR-1:0][AWP-1:0]    addr_r,
  output logic [NR-1:0][WIDTH-1:0]  rdata,
  input  logic [NW-1:0][AWP-1:0]    addr_w,
  input  logic [NW-1:0]             we,
  input  logic [NW-1:0][WIDTH-1:0]  wdata,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic                      clr_done
);

  logic [COUNT-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NR-1:0][WIDTH-1:0]    rd_s;
  logic [NR-1:0]               hit_s;
  logic                        sweep_en_s;
  logic [AWP-1:0]              sweep_addr_s;
  logic                        idle_s;

  regfile_clr_fsm #(
    .COUNT (COUNT),
    .AWP   (AWP)
  ) u_clr_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_req_i    (clr_req),
    .clr_busy_o   (clr_busy),
    .clr_done_o   (clr_done),
    .sweep_en_o   (sweep_en_s),
    .sweep_addr_o (sweep_addr_s)
  );

  assign idle_s = ~(clr_busy | clr_done);

  // Write merge: ascending port order so the highest index wins a conflict.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < COUNT; k++) begin
      for (int j = 0; j < NW; j++) begin
        regs_d[k] = (idle_s && we[j] && (addr_w[j] == AWP'(k))) ? wdata[j] : regs_d[k];
      end
      regs_d[k] = (sweep_en_s && (sweep_addr_s == AWP'(k))) ? '0 : regs_d[k];
      regs_d[k] = ((ZERO_REG != 0) && (k == 0)) ? '0 : regs_d[k];
    end
  end

  // Register array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read mux; an address matching no register (out of range) yields zero.
  always_comb begin
    rd_s  = '0;
    hit_s = '0;
    for (int i = 0; i < NR; i++) begin
      for (int k = 0; k < COUNT; k++) begin
        rd_s[i]  = rd_s[i] | (regs_q[k] & {WIDTH{addr_r[i] == AWP'(k)}});
        hit_s[i] = hit_s[i] | (addr_r[i] == AWP'(k));
      end
      for (int j = 0; j < NW; j++) begin
        rd_s[i] = ((BYPASS != 0) && idle_s && hit_s[i] && we[j] && (addr_w[j] == addr_r[i]))
                  ? wdata[j] : rd_s[i];
      end
      rd_s[i] = ((ZERO_REG != 0) && (addr_r[i] == '0)) ? '0 : rd_s[i];
    end
  end

  assign rdata = rd_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: three configurations driven in lockstep against a behavioural model.
module tb_regfile_mp;

  localparam int N  = 32;
  localparam int NC = 24;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0][4:0]  addr_r, addr_w;
  logic [1:0]       we;
  logic [1:0][31:0] wdata;
  logic             clr_req;
  logic [1:0][31:0] rd_a, rd_b, rd_c;
  logic busy_a, done_a, busy_b, done_b, busy_c, done_c;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(32), .COUNT(N), .NR(2), .NW(2), .BYPASS(0), .ZERO_REG(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .addr_r(addr_r), .rdata(rd_a), .addr_w(addr_w), .we(we),
    .wdata(wdata), .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a));

  regfile_mp #(.WIDTH(32), .COUNT(N), .NR(2), .NW(2), .BYPASS(1), .ZERO_REG(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .addr_r(addr_r), .rdata(rd_b), .addr_w(addr_w), .we(we),
    .wdata(wdata), .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b));

  regfile_mp #(.WIDTH(32), .COUNT(NC), .NR(2), .NW(2), .BYPASS(0), .ZERO_REG(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .addr_r(addr_r), .rdata(rd_c), .addr_w(addr_w), .we(we),
    .wdata(wdata), .clr_req(1'b0), .clr_busy(busy_c), .clr_done(done_c));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] ma[N];
  logic [31:0] mb[N];
  logic [31:0] mc[NC];
  int          m_st;
  int          m_ptr;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end
    for (int k = 0; k < NC; k++) mc[k] = '0;
    m_st  = 0;
    m_ptr = 0;
  endtask

  function automatic logic [31:0] exp_rd(input int dut, input int i);
    int a;
    logic [31:0] v;
    a = int'(addr_r[i]);
    v = '0;
    case (dut)
      0: v = ma[a];
      1: begin
        v = mb[a];
        if (m_st == 0) begin
          for (int j = 0; j < 2; j++)
            if (we[j] && addr_w[j] == addr_r[i]) v = wdata[j];
        end
        if (a == 0) v = '0;
      end
      2: if (a < NC) v = mc[a];
      default: v = '0;
    endcase
    return v;
  endfunction

  // Advance one clock edge and apply the spec behaviour to the model.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int j = 0; j < 2; j++)
        if (we[j] && int'(addr_w[j]) < NC) mc[addr_w[j]] = wdata[j];
      if (m_st == 0) begin
        for (int j = 0; j < 2; j++) begin
          if (we[j]) begin
            ma[addr_w[j]] = wdata[j];
            if (addr_w[j] != 5'd0) mb[addr_w[j]] = wdata[j];
          end
        end
        if (clr_req) begin
          m_st  = 1;
          m_ptr = 0;
        end
      end else if (m_st == 1) begin
        ma[m_ptr] = '0;
        mb[m_ptr] = '0;
        if (m_ptr == N - 1) m_st = 2;
        m_ptr++;
      end else begin
        m_st = 0;
      end
    end
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] obs[10];
    push({tag, "/a0"}, exp_rd(0, 0));
    push({tag, "/a1"}, exp_rd(0, 1));
    push({tag, "/b0"}, exp_rd(1, 0));
    push({tag, "/b1"}, exp_rd(1, 1));
    push({tag, "/c0"}, exp_rd(2, 0));
    push({tag, "/c1"}, exp_rd(2, 1));
    push({tag, "/busy_a"}, {31'd0, m_st == 1});
    push({tag, "/done_a"}, {31'd0, m_st == 2});
    push({tag, "/busy_b"}, {31'd0, m_st == 1});
    push({tag, "/done_b"}, {31'd0, m_st == 2});
    #1;
    obs = '{rd_a[0], rd_a[1], rd_b[0], rd_b[1], rd_c[0], rd_c[1],
            {31'd0, busy_a}, {31'd0, done_a}, {31'd0, busy_b}, {31'd0, done_b}};
    for (int k = 0; k < 10; k++) begin
      sb_t e;
      e = sbq.pop_front();
      check_eq(e.tag, obs[k], e.exp);
    end
  endtask

  task automatic sweep_reads(input string tag);
    we = 2'b00;
    for (int i = 0; i < N; i++) begin
      addr_r[0] = 5'(i);
      addr_r[1] = 5'(N - 1 - i);
      check_all(tag);
      tick();
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 16; i++) begin
      we        = 2'b11;
      addr_w[0] = 5'(i);
      addr_w[1] = 5'(i + 16);
      wdata[0]  = 32'(i + 1);
      wdata[1]  = 32'(i + 17);
      tick();
    end
    we = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    int done_cnt;
    rst_n   = 1'b1;
    clr_req = 1'b0;
    we      = 2'b00;
    addr_r  = '0;
    addr_w  = '0;
    wdata   = '0;
    #2;
    rst_n = 1'b0;
    model_reset();
    check_all("rst_hold");
    tick();
    rst_n = 1'b1;
    sweep_reads("rst_sweep");

    // Dual write on two ports, bypass visible only on the bypass instance.
    we = 2'b11; addr_w[0] = 5'd3; wdata[0] = 32'hA5; addr_w[1] = 5'd7; wdata[1] = 32'h5A;
    addr_r[0] = 5'd3; addr_r[1] = 5'd7;
    check_all("dual_pre");
    tick();
    we = 2'b00;
    check_all("dual_post");
    addr_r[1] = 5'd3;
    check_all("dual_r3");
    tick();

    we = 2'b11; addr_w[0] = 5'd4; wdata[0] = 32'h11; addr_w[1] = 5'd4; wdata[1] = 32'h22;
    addr_r[0] = 5'd4; addr_r[1] = 5'd4;
    check_all("conf_pre");
    tick();
    we = 2'b00;
    check_all("conf_post");

    we = 2'b01; addr_w[0] = 5'd9; wdata[0] = 32'h1234; addr_r[0] = 5'd9; addr_r[1] = 5'd3;
    check_all("byp_pre");
    tick();
    we = 2'b00;
    check_all("byp_post");

    we = 2'b10; addr_w[1] = 5'd0; wdata[1] = 32'hFFFF_FFFF; addr_r[0] = 5'd0; addr_r[1] = 5'd9;
    check_all("zero_pre");
    tick();
    we = 2'b00;
    check_all("zero_post");

    // Out-of-range handling on the 24-entry instance.
    we = 2'b11; addr_w[0] = 5'd23; wdata[0] = 32'hBEEF; addr_w[1] = 5'd25; wdata[1] = 32'hDEAD;
    addr_r[0] = 5'd23; addr_r[1] = 5'd25;
    check_all("oor_pre");
    tick();
    we = 2'b00;
    check_all("oor_post");

    fill();
    sweep_reads("fill");

    clr_req  = 1'b1;
    addr_r[0] = 5'd0; addr_r[1] = 5'd20;
    tick();
    clr_req  = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (busy_a) busy_cnt++;
      if (done_a) done_cnt++;
      addr_r[0] = 5'(cyc % N);
      if (cyc == 5) begin
        we = 2'b01; addr_w[0] = 5'd20; wdata[0] = 32'h77;
      end else begin
        we = 2'b00;
      end
      check_all("sweep");
      tick();
    end
    we = 2'b00;
    check_eq("busy_len", 32'(busy_cnt), 32'd32);
    check_eq("done_len", 32'(done_cnt), 32'd1);
    sweep_reads("after_clr");

    fill();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) tick();
    rst_n = 1'b0;
    model_reset();
    check_all("rst_mid");
    for (int i = 0; i < N; i++) begin
      addr_r[0] = 5'(i);
      addr_r[1] = 5'(N - 1 - i);
      check_all("rst_mid_rd");
    end
    #3;
    rst_n = 1'b1;
    tick();
    done_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done_a || done_b) done_cnt++;
      check_all("post_rst");
      tick();
    end
    check_eq("no_done", 32'(done_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
